// File: rtl/dmac_ahb_pkg.sv
// Shared AHB-Lite encodings, responder FSM states and lane-mask helper.
package dmac_ahb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned WAIT_W = 4;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [1:0] {
    HSIZE_BYTE = 2'b00,
    HSIZE_HALF = 2'b01,
    HSIZE_WORD = 2'b10,
    HSIZE_ILL  = 2'b11
  } hsize_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } ahb_slv_state_e;

  // Byte lanes touched by a transfer of the given size at the given byte offset.
  function automatic logic [STRB_W-1:0] lane_mask(input hsize_e size, input logic [1:0] addr_lo);
    logic [STRB_W-1:0] m;
    m = '0;
    case (size)
      HSIZE_BYTE: m = 4'b0001 << addr_lo;
      HSIZE_HALF: m = 4'b0011 << addr_lo;
      HSIZE_WORD: m = 4'b1111;
      default:    m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmac_ahb_sram.sv
// Word-organised SRAM: asynchronous read, byte-enable synchronous write, no reset.
module dmac_ahb_sram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  assign rdata = mem[addr];

  // Byte-lane write on enabled lanes only.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/dmac_ahb_slave_mem.sv
// AHB-Lite responder in front of a word SRAM: wait states, byte strobes, two-cycle ERROR.
module dmac_ahb_slave_mem
  import dmac_ahb_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HSel,
  input  logic [31:0] HAddr,
  input  logic [1:0]  HTrans,
  input  logic        HWrite,
  input  logic [1:0]  HSize,
  input  logic [3:0]  HBurst,
  input  logic [3:0]  HWStrb,
  input  logic [31:0] HWData,
  input  logic        HReadyIn,
  output logic        HReadyOut,
  output logic [1:0]  HResp,
  output logic [31:0] HRData
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] SPAN      = 32'(DEPTH * 4);
  localparam logic [3:0]  LAST_WAIT = 4'(WAIT_STATES - 1);
  localparam logic        HAS_WAIT  = (WAIT_STATES != 0);

  ahb_slv_state_e state_q, state_d, accept_state;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [AW-1:0]     dp_word_q;
  logic [1:0]        dp_lo_q;
  logic              dp_write_q;
  hsize_e            dp_size_q;

  htrans_e     htrans;
  hsize_e      hsize;
  hresp_e      hresp;
  logic [31:0] offset;
  logic        xfer, addr_err, dp_load;
  logic        sram_we;
  logic [3:0]  sram_be;
  logic [31:0] sram_rdata;
  logic        unused_burst;

  assign htrans       = htrans_e'(HTrans);
  assign hsize        = hsize_e'(HSize);
  assign offset       = HAddr - BASE_ADDR;
  assign xfer         = HSel & HReadyIn & (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
  assign dp_load      = xfer & (state_q == ST_IDLE || state_q == ST_DATA || state_q == ST_ERR2);
  assign accept_state = addr_err ? ST_ERR1 : (HAS_WAIT ? ST_WAIT : ST_DATA);
  assign HResp        = hresp;
  assign unused_burst = ^HBurst;

  // Address-phase legality: window, illegal size, misalignment.
  always_comb begin
    addr_err = 1'b0;
    if (offset >= SPAN) addr_err = 1'b1;
    case (hsize)
      HSIZE_ILL:  addr_err = 1'b1;
      HSIZE_HALF: if (HAddr[0]) addr_err = 1'b1;
      HSIZE_WORD: if (HAddr[1:0] != 2'b00) addr_err = 1'b1;
      default:    ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:          if (xfer) state_d = accept_state;
      ST_WAIT:          if (wait_cnt_q == LAST_WAIT) state_d = ST_DATA;
      ST_DATA, ST_ERR2: state_d = xfer ? accept_state : ST_IDLE;
      ST_ERR1:          state_d = ST_ERR2;
      default:          state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake, response, read data and SRAM write strobe.
  always_comb begin
    HReadyOut = 1'b1;
    hresp     = HRESP_OKAY;
    HRData    = '0;
    sram_we   = 1'b0;
    sram_be   = '0;
    case (state_q)
      ST_WAIT: begin
        HReadyOut = 1'b0;
        if (!dp_write_q) HRData = sram_rdata;
      end
      ST_DATA: begin
        if (dp_write_q) begin
          sram_we = ~rst;
          sram_be = HWStrb & lane_mask(dp_size_q, dp_lo_q);
        end else begin
          HRData = sram_rdata;
        end
      end
      ST_ERR1: begin
        HReadyOut = 1'b0;
        hresp     = HRESP_ERROR;
      end
      ST_ERR2: hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  // Wait-state counter, cleared whenever the FSM is not mid-wait.
  always_ff @(posedge clk) begin
    if (rst)                                              wait_cnt_q <= '0;
    else if (state_q == ST_WAIT && wait_cnt_q != LAST_WAIT) wait_cnt_q <= wait_cnt_q + 4'd1;
    else                                                  wait_cnt_q <= '0;
  end

  // Data-phase context captured on each accepted address phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_word_q  <= '0;
      dp_lo_q    <= '0;
      dp_write_q <= 1'b0;
      dp_size_q  <= HSIZE_BYTE;
    end else if (dp_load) begin
      dp_word_q  <= offset[AW+1:2];
      dp_lo_q    <= offset[1:0];
      dp_write_q <= HWrite;
      dp_size_q  <= hsize;
    end
  end

  dmac_ahb_sram #(.DEPTH(DEPTH), .AW(AW)) u_sram (
    .clk   (clk),
    .we    (sram_we),
    .be    (sram_be),
    .addr  (dp_word_q),
    .wdata (HWData),
    .rdata (sram_rdata)
  );

endmodule

// File: tb/tb_dmac_ahb_slave_mem.sv
// Directed bench: two responders (0 and 2 wait states) on a shared bus, one selected at a time.
module tb_dmac_ahb_slave_mem;

  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        clk;
  logic        rst;
  logic        use_ws0;
  logic        hsel, hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans, hsize;
  logic [3:0]  hburst, hwstrb;
  logic        hsel0, hsel2;
  logic        ro0, ro2, rdy;
  logic [1:0]  resp0, resp2, resp;
  logic [31:0] rd0, rd2, rdata;

  int vec_cnt = 0;
  int err_cnt = 0;

  assign hsel0 = hsel & use_ws0;
  assign hsel2 = hsel & ~use_ws0;
  assign rdy   = use_ws0 ? ro0 : ro2;
  assign resp  = use_ws0 ? resp0 : resp2;
  assign rdata = use_ws0 ? rd0 : rd2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmac_ahb_slave_mem #(.DEPTH(256), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .HSel(hsel0), .HAddr(haddr), .HTrans(htrans), .HWrite(hwrite),
    .HSize(hsize), .HBurst(hburst), .HWStrb(hwstrb), .HWData(hwdata), .HReadyIn(ro0),
    .HReadyOut(ro0), .HResp(resp0), .HRData(rd0));

  dmac_ahb_slave_mem #(.DEPTH(256), .BASE_ADDR(BASE), .WAIT_STATES(2)) dut2 (
    .clk(clk), .rst(rst), .HSel(hsel2), .HAddr(haddr), .HTrans(htrans), .HWrite(hwrite),
    .HSize(hsize), .HBurst(hburst), .HWStrb(hwstrb), .HWData(hwdata), .HReadyIn(ro2),
    .HReadyOut(ro2), .HResp(resp2), .HRData(rd2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One non-pipelined transfer; reports response of first and final data-phase cycles.
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                         input logic [3:0] strb, input logic [31:0] wd,
                         output logic [31:0] rd, output logic [1:0] rf,
                         output logic [1:0] rl, output int nw);
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size; hburst = 4'd0;
    step();
    hsel = 1'b0; htrans = 2'b00; hwdata = wd; hwstrb = strb;
    nw = 0;
    rf = resp;
    while (rdy !== 1'b1 && nw < 20) begin
      nw++;
      step();
    end
    rd = rdata;
    rl = resp;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vec_cnt++; if ({ro0, ro2} !== 2'b11) begin err_cnt++; $display("FAIL reset_ready got %b want 11", {ro0, ro2}); end
    vec_cnt++; if ({resp0, resp2} !== 4'b0) begin err_cnt++; $display("FAIL reset_resp got %b want 0000", {resp0, resp2}); end
    vec_cnt++; if ((rd0 | rd2) !== 32'h0) begin err_cnt++; $display("FAIL reset_rdata got %h/%h want 0", rd0, rd2); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_ws0();
    logic [31:0] rd; logic [1:0] rf, rl; int nw;
    use_ws0 = 1'b1;
    do_xfer(1'b1, BASE + 32'h10, 2'b10, 4'hF, 32'hDEAD_BEEF, rd, rf, rl, nw);
    vec_cnt++; if (nw !== 0 || rl !== 2'b00) begin err_cnt++; $display("FAIL ws0_write got waits=%0d resp=%b want 0/00", nw, rl); end
    do_xfer(1'b0, BASE + 32'h10, 2'b10, 4'h0, 32'h0, rd, rf, rl, nw);
    vec_cnt++; if (rd !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL ws0_read_data got %h want deadbeef", rd); end
    vec_cnt++; if (nw !== 0 || rl !== 2'b00) begin err_cnt++; $display("FAIL ws0_read got waits=%0d resp=%b want 0/00", nw, rl); end
    vec_cnt++; if (rdata !== 32'h0) begin err_cnt++; $display("FAIL ws0_idle_rdata got %h want 0", rdata); end
  endtask

  task automatic test_back_to_back();
    use_ws0 = 1'b1;
    hsel = 1'b1; htrans = 2'b10; haddr = BASE + 32'h20; hwrite = 1'b1; hsize = 2'b10;
    step();
    hwdata = 32'hCAFE_F00D; hwstrb = 4'hF; hwrite = 1'b0;
    vec_cnt++; if (rdy !== 1'b1) begin err_cnt++; $display("FAIL b2b_wr_ready got %b want 1", rdy); end
    step();
    hsel = 1'b0; htrans = 2'b00;
    vec_cnt++; if (rdy !== 1'b1 || rdata !== 32'hCAFE_F00D) begin err_cnt++; $display("FAIL b2b_read got rdy=%b data=%h want 1/cafef00d", rdy, rdata); end
    step();
  endtask

  task automatic test_incr4_wait();
    int nw;
    use_ws0 = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      hsel = 1'b1; htrans = 2'b10; haddr = BASE; hwrite = (pass == 0); hsize = 2'b10; hburst = 4'b0011;
      step();
      for (int k = 0; k < 4; k++) begin
        hwdata = 32'hA000_0000 + 32'(k); hwstrb = 4'hF;
        if (k < 3) begin htrans = 2'b11; haddr = BASE + 32'(4 * (k + 1)); end
        else begin hsel = 1'b0; htrans = 2'b00; end
        nw = 0;
        while (rdy !== 1'b1 && nw < 20) begin nw++; step(); end
        vec_cnt++; if (nw !== 2 || resp !== 2'b00) begin err_cnt++; $display("FAIL incr4_p%0d_beat%0d got waits=%0d resp=%b want 2/00", pass, k, nw, resp); end
        if (pass == 1) begin
          vec_cnt++; if (rdata !== 32'hA000_0000 + 32'(k)) begin err_cnt++; $display("FAIL incr4_rd_beat%0d got %h want %h", k, rdata, 32'hA000_0000 + 32'(k)); end
        end
        step();
      end
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic [1:0] rf, rl; int nw;
    use_ws0 = 1'b0;
    do_xfer(1'b1, BASE + 32'h10, 2'b10, 4'hF, 32'h1122_3344, rd, rf, rl, nw);
    do_xfer(1'b1, BASE + 32'h13, 2'b00, 4'hF, 32'hAABB_CCDD, rd, rf, rl, nw);
    vec_cnt++; if (rl !== 2'b00) begin err_cnt++; $display("FAIL byte_wr_resp got %b want 00", rl); end
    do_xfer(1'b0, BASE + 32'h10, 2'b10, 4'h0, 32'h0, rd, rf, rl, nw);
    vec_cnt++; if (rd !== 32'hAA22_3344) begin err_cnt++; $display("FAIL byte_lane got %h want aa223344", rd); end
    do_xfer(1'b1, BASE + 32'h10, 2'b01, 4'hF, 32'h5555_9999, rd, rf, rl, nw);
    do_xfer(1'b0, BASE + 32'h10, 2'b10, 4'h0, 32'h0, rd, rf, rl, nw);
    vec_cnt++; if (rd !== 32'hAA22_9999) begin err_cnt++; $display("FAIL half_lane got %h want aa229999", rd); end
  endtask

  task automatic test_range_error();
    logic [31:0] rd; logic [1:0] rf, rl; int nw;
    use_ws0 = 1'b0;
    do_xfer(1'b0, BASE + 32'h400, 2'b10, 4'h0, 32'h0, rd, rf, rl, nw);
    vec_cnt++; if (nw !== 1 || rf !== 2'b01 || rl !== 2'b01) begin err_cnt++; $display("FAIL range_hi got waits=%0d resp=%b/%b want 1/01/01", nw, rf, rl); end
    do_xfer(1'b0, BASE - 32'h4, 2'b10, 4'h0, 32'h0, rd, rf, rl, nw);
    vec_cnt++; if (nw !== 1 || rl !== 2'b01) begin err_cnt++; $display("FAIL range_lo got waits=%0d resp=%b want 1/01", nw, rl); end
    do_xfer(1'b0, BASE, 2'b10, 4'h0, 32'h0, rd, rf, rl, nw);
    vec_cnt++; if (nw !== 2 || rl !== 2'b00 || rd !== 32'hA000_0000) begin err_cnt++; $display("FAIL after_err got waits=%0d resp=%b data=%h want 2/00/a0000000", nw, rl, rd); end
  endtask

  task automatic test_align_error();
    logic [31:0] rd; logic [1:0] rf, rl; int nw;
    use_ws0 = 1'b0;
    do_xfer(1'b0, BASE + 32'h2, 2'b10, 4'h0, 32'h0, rd, rf, rl, nw);
    vec_cnt++; if (nw !== 1 || rf !== 2'b01 || rl !== 2'b01) begin err_cnt++; $display("FAIL word_misalign got waits=%0d resp=%b/%b want 1/01/01", nw, rf, rl); end
    do_xfer(1'b0, BASE, 2'b11, 4'h0, 32'h0, rd, rf, rl, nw);
    vec_cnt++; if (nw !== 1 || rl !== 2'b01) begin err_cnt++; $display("FAIL size11 got waits=%0d resp=%b want 1/01", nw, rl); end
    do_xfer(1'b1, BASE + 32'h2, 2'b10, 4'hF, 32'hFFFF_FFFF, rd, rf, rl, nw);
    vec_cnt++; if (rl !== 2'b01) begin err_cnt++; $display("FAIL wr_misalign_resp got %b want 01", rl); end
    do_xfer(1'b1, BASE, 2'b11, 4'hF, 32'hFFFF_FFFF, rd, rf, rl, nw);
    do_xfer(1'b1, BASE + 32'h5, 2'b01, 4'hF, 32'hFFFF_FFFF, rd, rf, rl, nw);
    vec_cnt++; if (rl !== 2'b01) begin err_cnt++; $display("FAIL half_odd_resp got %b want 01", rl); end
    do_xfer(1'b0, BASE, 2'b10, 4'h0, 32'h0, rd, rf, rl, nw);
    vec_cnt++; if (rd !== 32'hA000_0000) begin err_cnt++; $display("FAIL err_no_write0 got %h want a0000000", rd); end
    do_xfer(1'b0, BASE + 32'h4, 2'b10, 4'h0, 32'h0, rd, rf, rl, nw);
    vec_cnt++; if (rd !== 32'hA000_0001) begin err_cnt++; $display("FAIL err_no_write1 got %h want a0000001", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic [1:0] rf, rl; int nw;
    use_ws0 = 1'b0;
    hsel = 1'b1; htrans = 2'b10; haddr = BASE + 32'h4; hwrite = 1'b1; hsize = 2'b10;
    step();
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0BAD_F00D; hwstrb = 4'hF;
    vec_cnt++; if (rdy !== 1'b0) begin err_cnt++; $display("FAIL mid_in_wait got ready=%b want 0", rdy); end
    rst = 1'b1;
    step();
    vec_cnt++; if (rdy !== 1'b1 || resp !== 2'b00) begin err_cnt++; $display("FAIL mid_rst got ready=%b resp=%b want 1/00", rdy, resp); end
    rst = 1'b0;
    step();
    do_xfer(1'b0, BASE + 32'h4, 2'b10, 4'h0, 32'h0, rd, rf, rl, nw);
    vec_cnt++; if (rd !== 32'hA000_0001 || rl !== 2'b00) begin err_cnt++; $display("FAIL mid_rst_word got %h resp=%b want a0000001/00", rd, rl); end
  endtask

  initial begin
    rst = 1'b1; use_ws0 = 1'b1; hsel = 1'b0; hwrite = 1'b0; haddr = '0; hwdata = '0;
    htrans = 2'b00; hsize = 2'b10; hburst = 4'd0; hwstrb = 4'h0;
    test_reset();
    test_basic_ws0();
    test_back_to_back();
    test_incr4_wait();
    test_byte_lanes();
    test_range_error();
    test_align_error();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
